sprite_motion_engine: RTL
=========================

// Module: sprite_motion_engine
// PURPOSE
//  Parametrised gravity/flap motion engine for a vertically moving player sprite.
//  Successor to the fixed-constant bird motion FSM: timing, screen and sprite sizes are
//  parameters; floor/ceiling clamping and a pause that takes priority are added.
//  Sits between the game FSM/flap input and the image renderer (pos_y, frame, angle).
// PARAMETERS
//  Y_W            10      width of pos_y
//  CNT_W          20      width of period/elapsed counters (must hold TIME_MAX+TIME_STEP)
//  SCREEN_H       480     visible height, pixels
//  SPRITE_H       24      sprite height, pixels; floor = SCREEN_H-SPRITE_H
//  START_Y        228     reset position
//  AUTO_FLAP_Y    250     START_SCREEN demo: auto-flap when pos_y > this
//  TIME_START     25000   period loaded on flap
//  TIME_STEP      5000    per-pixel period change
//  TIME_MAX       475000  fall start period / rise end period
//  TIME_TERMINAL  150000  minimum fall period
// PORTS
//  clk         in   1     system clock
//  rst         in   1     asynchronous, active-low reset
//  flap        in   1     one-cycle flap request
//  game_state  in   4     one-hot: START_SCREEN=0001 IN_GAME=0010 PAUSE=0100 END_SCREEN=1000
//  pos_y       out  Y_W   sprite top row
//  sprite_frame out 2     0=FLAP_1 1=FLAP_2 2=FLAP_3
//  sprite_angle out 2     0=HORZ 1=POS_45 2=NEG_45
//  floor_hit   out  1     high while pos_y == floor
//  ceil_hit    out  1     high while pos_y == 0
//  motion_state out 2     0=FALL 1=RISE 2=APEX 3=HALT (debug)
// BEHAVIOUR
//  Reset (rst low, async): state FALL, saved state FALL, period=elapsed=TIME_MAX,
//   pos_y=START_Y, frame FLAP_1, angle HORZ, floor_hit/ceil_hit from START_Y.
//  Priority each cycle: halt > flap > step. game_state PAUSE or END_SCREEN in any
//   non-HALT state -> HALT next cycle, current state saved; nothing else updates that cycle.
//  HALT: all registers frozen; when game_state is START_SCREEN or IN_GAME return to saved
//   state next cycle with period/elapsed unchanged (motion resumes exactly).
//  FALL: elapsed-=1 per cycle. At elapsed==0: pos_y+1, saturating at floor;
//   period=max(period-TIME_STEP, TIME_TERMINAL); elapsed<=new period.
//   frame = period>=3*TIME_MAX/5 ? FLAP_2 : FLAP_1; angle = period>=4*TIME_MAX/5 ? HORZ : POS_45.
//  Flap trigger in FALL: flap, or (START_SCREEN and pos_y>AUTO_FLAP_Y and pos_y<floor)
//   -> RISE next cycle, period=elapsed=TIME_START, frame FLAP_3; step suppressed that cycle.
//  RISE: elapsed-=1. At elapsed==0: if period<=TIME_MAX: pos_y-1 saturating at 0,
//   period+=TIME_STEP, elapsed<=new period; else -> APEX.
//   frame = period<=3*TIME_MAX/5 ? FLAP_3 : FLAP_2; angle = period<=4*TIME_MAX/5 ? NEG_45 : HORZ.
//  APEX: one cycle; frame FLAP_2, angle HORZ, period=elapsed=TIME_MAX -> FALL.
//  All arithmetic unsigned CNT_W/Y_W; no wrap: pos_y never <0 or >floor.
//  Thresholds are elaboration-time constants (integer division as written).
// CONFIGURATION
//  FLAP_RETRIGGER_EN defined: flap in RISE restarts rise (period=elapsed=TIME_START, FLAP_3).
//  Undefined: flap ignored in RISE and APEX; only FALL accepts flaps.
// STRUCTURE
//  Shared header game_defs.vh: game_state one-hot codes, frame and angle codes,
//   motion_state encodings (used by renderer and game FSM too).
//  Sub-module motion_timer: CNT_W down-counter with load/enable/zero flag; instantiated once.
// TESTING (sim with TIME_* scaled down, e.g. START=5 STEP=1 MAX=20 TERMINAL=8)
//  Reset low mid-RISE -> same cycle pos_y=START_Y, state FALL, period=elapsed=TIME_MAX.
//  IN_GAME, no flap, long run -> fall period steps 20,19..8 then holds 8; pos_y stops at floor, floor_hit=1.
//  flap in FALL -> RISE next cycle, periods 5,6..20 per pixel, then APEX 1 cycle, then FALL.
//  PAUSE asserted in cycle where elapsed==0 -> HALT, pos_y unchanged; IN_GAME -> resumes, same elapsed.
//  Repeated flaps at pos_y=0 -> pos_y stays 0, ceil_hit=1, no underflow.
//  flap in RISE -> restart rise with FLAP_RETRIGGER_EN; no effect without it.

Source files
------------

// File: rtl/sprite_motion_engine_pkg.sv
// sprite_motion_engine_pkg: shared game_state, frame, angle and motion_state codes
package sprite_motion_engine_pkg;
  localparam logic [3:0] GS_START   = 4'b0001;
  localparam logic [3:0] GS_IN_GAME = 4'b0010;
  localparam logic [3:0] GS_PAUSE   = 4'b0100;
  localparam logic [3:0] GS_END     = 4'b1000;
  localparam logic [1:0] FLAP_1 = 2'd0;
  localparam logic [1:0] FLAP_2 = 2'd1;
  localparam logic [1:0] FLAP_3 = 2'd2;
  localparam logic [1:0] HORZ   = 2'd0;
  localparam logic [1:0] POS_45 = 2'd1;
  localparam logic [1:0] NEG_45 = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_APEX = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;
  function automatic logic gs_runs(input logic [3:0] gs);
    return gs == GS_START || gs == GS_IN_GAME;
  endfunction
  function automatic logic gs_stops(input logic [3:0] gs);
    return gs == GS_PAUSE || gs == GS_END;
  endfunction
endpackage

// File: rtl/sprite_motion_engine_motion_timer.sv
// motion_timer: loadable down-counter whose zero flag paces one pixel step
module motion_timer #(
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // load wins over counting; a disabled counter holds its value
  always_comb cnt_d = load ? load_val : en ? cnt_q - 1'b1 : cnt_q;
  // elapsed counter register, active-low asynchronous reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: gravity/flap vertical motion with clamping and pause; FLAP_RETRIGGER_EN lets a flap restart a rise
module sprite_motion_engine
  import sprite_motion_engine_pkg::*;
#(
  parameter int Y_W           = 10,
  parameter int CNT_W         = 20,
  parameter int SCREEN_H      = 480,
  parameter int SPRITE_H      = 24,
  parameter int START_Y       = 228,
  parameter int AUTO_FLAP_Y   = 250,
  parameter int TIME_START    = 25000,
  parameter int TIME_STEP     = 5000,
  parameter int TIME_MAX      = 475000,
  parameter int TIME_TERMINAL = 150000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flap,
  input  logic [3:0]     game_state,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     sprite_frame,
  output logic [1:0]     sprite_angle,
  output logic           floor_hit,
  output logic           ceil_hit,
  output logic [1:0]     motion_state
);
  localparam logic [Y_W-1:0]   FLOOR_Y  = Y_W'(SCREEN_H - SPRITE_H);
  localparam logic [Y_W-1:0]   RST_Y    = Y_W'(START_Y);
  localparam logic [Y_W-1:0]   AUTO_Y   = Y_W'(AUTO_FLAP_Y);
  localparam logic [CNT_W-1:0] T_START  = CNT_W'(TIME_START);
  localparam logic [CNT_W-1:0] T_STEP   = CNT_W'(TIME_STEP);
  localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(TIME_MAX);
  localparam logic [CNT_W-1:0] T_TERM   = CNT_W'(TIME_TERMINAL);
  localparam logic [CNT_W-1:0] T_SLOW   = CNT_W'(TIME_TERMINAL + TIME_STEP);
  localparam logic [CNT_W-1:0] FRAME_TH = CNT_W'(3 * TIME_MAX / 5);
  localparam logic [CNT_W-1:0] ANGLE_TH = CNT_W'(4 * TIME_MAX / 5);
  logic [1:0]       state_q, state_d, saved_q, saved_d, frame_q, frame_d, angle_q, angle_d;
  logic [Y_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             zero, load, en, halt_req, resume, trig, retrig;
  motion_timer #(.CNT_W(CNT_W), .RST_VAL(T_MAX)) u_timer (
    .clk(clk), .rst(rst), .load(load), .en(en), .load_val(period_d), .zero(zero)
  );
  // next-state: halt beats flap, flap beats the per-pixel step
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    frame_d  = frame_q;
    angle_d  = angle_q;
    pos_d    = pos_q;
    period_d = period_q;
    load     = 1'b0;
    en       = 1'b0;
    halt_req = state_q != ST_HALT && gs_stops(game_state);
    resume   = state_q == ST_HALT && gs_runs(game_state);
`ifdef FLAP_RETRIGGER_EN
    retrig   = state_q == ST_RISE && flap;
`else
    retrig   = 1'b0;
`endif
    trig     = retrig || (state_q == ST_FALL &&
               (flap || (game_state == GS_START && pos_q > AUTO_Y && pos_q < FLOOR_Y)));
    if (halt_req) begin
      state_d = ST_HALT;
      saved_d = state_q;
    end else if (resume) begin
      state_d = saved_q;
    end else if (trig) begin
      state_d  = ST_RISE;
      period_d = T_START;
      load     = 1'b1;
      frame_d  = FLAP_3;
    end else if (state_q == ST_APEX) begin
      state_d  = ST_FALL;
      period_d = T_MAX;
      load     = 1'b1;
      frame_d  = FLAP_2;
      angle_d  = HORZ;
    end else if (state_q == ST_FALL) begin
      en = !zero;
      if (zero) begin
        pos_d    = pos_q < FLOOR_Y ? pos_q + 1'b1 : pos_q;
        period_d = period_q >= T_SLOW ? period_q - T_STEP : T_TERM;
        load     = 1'b1;
        frame_d  = period_d >= FRAME_TH ? FLAP_2 : FLAP_1;
        angle_d  = period_d >= ANGLE_TH ? HORZ : POS_45;
      end
    end else if (state_q == ST_RISE) begin
      en = !zero;
      if (zero && period_q <= T_MAX) begin
        pos_d    = pos_q != '0 ? pos_q - 1'b1 : pos_q;
        period_d = period_q + T_STEP;
        load     = 1'b1;
        frame_d  = period_d <= FRAME_TH ? FLAP_3 : FLAP_2;
        angle_d  = period_d <= ANGLE_TH ? NEG_45 : HORZ;
      end else if (zero) begin
        state_d = ST_APEX;
      end
    end
  end
  // motion registers, active-low asynchronous reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= ST_FALL;
      saved_q  <= ST_FALL;
      frame_q  <= FLAP_1;
      angle_q  <= HORZ;
      pos_q    <= RST_Y;
      period_q <= T_MAX;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      frame_q  <= frame_d;
      angle_q  <= angle_d;
      pos_q    <= pos_d;
      period_q <= period_d;
    end
  assign pos_y        = pos_q;
  assign sprite_frame = frame_q;
  assign sprite_angle = angle_q;
  assign motion_state = state_q;
  assign floor_hit    = pos_q == FLOOR_Y;
  assign ceil_hit     = pos_q == '0;
endmodule
